muldiv_sched: RTL
=================

# muldiv_sched

Shared multiply/divide scheduler for the dual-issue execute stage. It arbitrates HI/LO-producing requests from the master and slave issue slots and runs each accepted request to completion. Multiplies take a fixed two-cycle path; divides run through an iterative 32-step divider. While a request is in flight, the block stalls the requesting slot. The single-cycle ALUs never see MULT/MULTU/DIV/DIVU; this block owns them.

## Interface
Parameters:
- DIV_STEPS, 32: divider iterations; fixed for 32-bit operands.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- resetn  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush (exception/eret); aborts in-flight op
- req_valid  in  2  per slot request; [0]=master, [1]=slave; held high until done[i]
- req_aluop  in  2x8  per slot opcode; ALUOP_MULT/MULTU/DIV/DIVU
- req_a  in  2x32  per slot rs operand
- req_b  in  2x32  per slot rt operand
- grant  out  2  one-hot; slot whose op is in flight
- stall  out  2  stall[i]=req_valid[i] & ~done[i]
- done  out  2  one-cycle pulse; result valid this cycle for slot i
- hi  out  32  HI result (mult high word / remainder); held until next done
- lo  out  32  LO result (mult low word / quotient); held until next done

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - If flush, stay in IDLE.
  - Else if any req_valid, grant the lowest index; master wins ties because it is the older instruction.
  - Latch aluop, a and b.
  - Go to MUL for MULT/MULTU, DIV for DIV/DIVU.
  - A non-muldiv aluop is ignored: no grant, stay in IDLE.
- MUL: compute the 64-bit product of the latched operands (signed for MULT, unsigned for MULTU). Register it into {hi,lo} and go to DONE.
- DIV: one iteration per cycle on the magnitudes; step counter 0..31. After step 31 apply the sign fix, load hi/lo and go to DONE.
- DONE:
  - Pulse done[granted slot].
  - Clear grant and go to IDLE.
  - IDLE never accepts in the same cycle as DONE, so there is always one bubble between operations.
- Signed divide rules:
  - Operate on |a| and |b|.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (defined, not trapped): lo=0xFFFFFFFF (DIVU; DIV with a≥0) and hi=a. For DIV with a<0, lo=0x00000001 and hi=a.
- flush in MUL/DIV/DONE:
  - Next state IDLE, grant cleared.
  - No done pulse.
  - hi/lo keep their previous values.
- Late requests: a req_valid arriving mid-operation waits; it is accepted from the next IDLE.

## Timing
- Reset values: grant=0, done=0, hi=0, lo=0, state IDLE, counter 0. stall follows req_valid combinationally, even during reset.
- Reset mid-operation aborts silently, same as flush, but hi/lo are cleared.
- Latency from the cycle t in which a request is accepted in IDLE:
  - mult: done high in cycle t+2
  - div: done high in cycle t+33
- Back-to-back: the losing slot is accepted at cycle t+3 (mult) or t+34 (div).
- hi/lo change only on the edge entering DONE and are stable from that point.
- Operands are latched at acceptance; changes to req_a/b afterward have no effect.

## Structure
- Shared package muldiv_pkg:
  - state enum typedef
  - slot index constants SLOT_MASTER=0, SLOT_SLAVE=1
- ALUOP_MULT/MULTU/DIV/DIVU stay in defines.vh alongside the other ALUOP codes.
- Sub-module div_iter: unsigned 32-bit restoring divider.
  - Ports: start pulse, 32-bit dividend and divisor, step counter, quotient and remainder.
  - muldiv_sched handles magnitude conversion and sign fix around it.
- Multiply is inline in muldiv_sched.

## Test plan
- MULT master, a=0xFFFFFFFF, b=2 → done[0] at t+2, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIVU slave, a=100, b=7 → grant=2'b10, done[1] at t+33, lo=14, hi=2; stall[1] high in cycles t..t+32.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Both slots request MULT in the same cycle → master done at t+2, slave accepted t+3 with done at t+5; stall[1] high throughout.
- DIV started, flush asserted at t+10 → no done pulse, hi/lo unchanged, IDLE at t+11; new MULTU accepted at t+11 completes normally at t+13.
- DIVU with b=0, a=0x1234 → lo=0xFFFFFFFF, hi=0x1234; resetn low mid-DIV → next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide scheduler
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int SLOT_MASTER = 0;
    localparam int SLOT_SLAVE  = 1;

    localparam logic [7:0] ALUOP_MULT  = 8'h18;
    localparam logic [7:0] ALUOP_MULTU = 8'h19;
    localparam logic [7:0] ALUOP_DIV   = 8'h1a;
    localparam logic [7:0] ALUOP_DIVU  = 8'h1b;

    function automatic logic is_muldiv(input logic [7:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_MULTU) ||
               (op == ALUOP_DIV)  || (op == ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// rtl/muldiv_sched_if.sv - request/result bundle between issue slots and the scheduler
interface muldiv_sched_if;

    logic [1:0]        req_valid;
    logic [1:0][7:0]   req_aluop;
    logic [1:0][31:0]  req_a;
    logic [1:0][31:0]  req_b;
    logic [1:0]        grant;
    logic [1:0]        stall;
    logic [1:0]        done;
    logic [31:0]       hi;
    logic [31:0]       lo;

    modport master (
        output req_valid, req_aluop, req_a, req_b,
        input  grant, stall, done, hi, lo
    );

    modport slave (
        input  req_valid, req_aluop, req_a, req_b,
        output grant, stall, done, hi, lo
    );

endinterface

// File: rtl/muldiv_sched_div_iter.sv
// rtl/muldiv_sched_div_iter.sv - unsigned restoring divider, one quotient bit per step
module div_iter #(
    parameter int STEPS  = 32,
    parameter int STEP_W = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic              en_i,
    input  logic [31:0]       dividend_i,
    input  logic [31:0]       divisor_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [31:0]       quotient_o,
    output logic [31:0]       remainder_o,
    output logic              last_o
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [33:0] diff;

    // Trial subtraction for the current step; outputs are the post-step values
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        if (diff[33]) begin
            remainder_o = shifted[31:0];
            quotient_o  = {quo_q[30:0], 1'b0};
        end else begin
            remainder_o = diff[31:0];
            quotient_o  = {quo_q[30:0], 1'b1};
        end
    end

    assign last_o = (step_i == STEP_W'(STEPS - 1));

    // Load operands on start, then commit one step per enabled cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (en_i) begin
            quo_q <= quotient_o;
            rem_q <= remainder_o;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - shared HI/LO multiply/divide scheduler for two issue slots
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    muldiv_sched_if.slave   bus
);

    localparam int CNT_W = $clog2(DIV_STEPS);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       a_q, b_q, hi_q, lo_q;
    logic              mul_signed_q, neg_quo_q, neg_rem_q;

    logic              sel;
    logic [7:0]        sel_op;
    logic [31:0]       sel_a, sel_b, a_mag, b_mag;
    logic              sel_signed, sel_is_div, a_neg, b_neg, accept;
    logic [63:0]       mul_a, mul_b, prod;
    logic [31:0]       quo, rem, div_lo, div_hi;
    logic              div_last, load_mul, load_div;
    logic [1:0]        done_w;

    // Pick the oldest requesting slot and prepare magnitudes for the divider
    always_comb begin
        sel        = ~bus.req_valid[SLOT_MASTER];
        sel_op     = bus.req_aluop[sel];
        sel_a      = bus.req_a[sel];
        sel_b      = bus.req_b[sel];
        sel_signed = (sel_op == ALUOP_MULT) || (sel_op == ALUOP_DIV);
        sel_is_div = (sel_op == ALUOP_DIV) || (sel_op == ALUOP_DIVU);
        a_neg      = sel_signed & sel_a[31];
        b_neg      = sel_signed & sel_b[31];
        a_mag      = a_neg ? (~sel_a + 32'd1) : sel_a;
        b_mag      = b_neg ? (~sel_b + 32'd1) : sel_b;
        accept     = (state_q == ST_IDLE) && !flush && (|bus.req_valid) && is_muldiv(sel_op);
    end

    div_iter #(.STEPS(DIV_STEPS), .STEP_W(CNT_W)) u_div (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (accept & sel_is_div),
        .en_i        (state_q == ST_DIV),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .step_i      (cnt_q),
        .quotient_o  (quo),
        .remainder_o (rem),
        .last_o      (div_last)
    );

    // Product in 64 bits: sign-extension of operands makes one multiplier serve both flavours
    always_comb begin
        mul_a  = {{32{mul_signed_q & a_q[31]}}, a_q};
        mul_b  = {{32{mul_signed_q & b_q[31]}}, b_q};
        prod   = mul_a * mul_b;
        div_lo = neg_quo_q ? (~quo + 32'd1) : quo;
        div_hi = neg_rem_q ? (~rem + 32'd1) : rem;
    end

    // Next-state and grant logic; flush drops any in-flight op back to IDLE
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = sel_is_div ? ST_DIV : ST_MUL;
                    grant_d = sel ? 2'b10 : 2'b01;
                end
            end
            ST_MUL:  state_d = ST_DONE;
            ST_DIV: begin
                if (div_last) state_d = ST_DONE;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
        if (flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            cnt_d   = '0;
        end
    end

    assign load_mul = (state_q == ST_MUL) && !flush;
    assign load_div = (state_q == ST_DIV) && div_last && !flush;

    // Control state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands and sign bookkeeping captured at acceptance only
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q          <= '0;
            b_q          <= '0;
            mul_signed_q <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
        end else if (accept) begin
            a_q          <= sel_a;
            b_q          <= sel_b;
            mul_signed_q <= sel_signed;
            neg_quo_q    <= a_neg ^ b_neg;
            neg_rem_q    <= a_neg;
        end
    end

    // HI/LO update only on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (load_mul) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
        end else if (load_div) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
        end
    end

    assign done_w    = ((state_q == ST_DONE) && !flush && resetn) ? grant_q : 2'b00;
    assign bus.grant = grant_q;
    assign bus.done  = done_w;
    assign bus.stall = bus.req_valid & ~done_w;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
